// File: rtl/hispi_calib_pkg.sv
// -----------------------------------------------------------------------------
// hispi_calib_pkg
// Shared types and helpers for the HiSPi lane calibration sequencer.
//   - calib_state_t : sequencer state encoding (explicit, legacy-compatible codes)
//   - calc_center   : window-centre tap from (start, length)
//   - DEF_*         : default parameter values
// -----------------------------------------------------------------------------
package hispi_calib_pkg;

    localparam int unsigned DEF_NUMB_LANE     = 6;
    localparam int unsigned DEF_TAP_WIDTH     = 5;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_SAMPLE_CYCLES = 16;
    localparam int unsigned DEF_MIN_WINDOW    = 4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StSettle = 3'd2,
        StSample = 3'd3,
        StEval   = 3'd4,
        StCenter = 3'd5,
        StNext   = 3'd6,
        StDone   = 3'd7
    } calib_state_t;

    // Caller truncates the result to its tap width.
    function automatic int unsigned calc_center(input int unsigned start,
                                                input int unsigned len);
        return start + (len >> 1);
    endfunction

endpackage

// File: rtl/hispi_calib_window.sv
// -----------------------------------------------------------------------------
// hispi_calib_window
// Tracks the longest contiguous run of passing taps during one lane's sweep.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   clear       drop current and best windows
//   valid       one tap result is presented this cycle
//   pass        tap result (1 = pass)
//   last        this is the top tap; the open window closes here (no wrap)
//   tap         tap index the result belongs to
//   best_start  first tap of the best window so far
//   best_len    length of the best window (TAP_WIDTH+1 bits, never overflows)
// -----------------------------------------------------------------------------
module hispi_calib_window #(
    parameter int unsigned TAP_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid,
    input  logic                 pass,
    input  logic                 last,
    input  logic [TAP_WIDTH-1:0] tap,
    output logic [TAP_WIDTH-1:0] best_start,
    output logic [TAP_WIDTH:0]   best_len
);

    logic [TAP_WIDTH-1:0] cur_start;
    logic [TAP_WIDTH:0]   cur_len;
    logic [TAP_WIDTH-1:0] nxt_start;
    logic [TAP_WIDTH:0]   nxt_len;
    logic                 close_win;

    // Window state including the current tap; the compare on close uses it so
    // a run ending at the top tap is counted in full.
    always_comb begin
        nxt_start = cur_start;
        nxt_len   = cur_len;
        if (pass) begin
            if (cur_len == '0) begin
                nxt_start = tap;
            end
            nxt_len = cur_len + (TAP_WIDTH+1)'(1);
        end
        close_win = !pass || last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clear) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (valid) begin
            if (close_win) begin
                // Strict compare: on a tie the earlier window is kept.
                if (nxt_len > best_len) begin
                    best_start <= nxt_start;
                    best_len   <= nxt_len;
                end
                cur_len <= '0;
            end else begin
                cur_start <= nxt_start;
                cur_len   <= nxt_len;
            end
        end
    end

endmodule

// File: rtl/hispi_lane_calib_ctrl.sv
// -----------------------------------------------------------------------------
// hispi_lane_calib_ctrl
// Per-lane bit-alignment sequencer for the HiSPi receive datapath. Sweeps each
// lane's input-delay tap, settles, samples pattern_ok, finds the longest
// passing window and loads its centre tap.
// Ports:
//   sysclk, sysrst  clock / asynchronous active-high reset
//   start           one-cycle pulse, calibrate all lanes (ignored while busy)
//   abort           level, stop and return to idle without a done pulse
//   pattern_ok      per-lane training-pattern match
//   tap_value       per-lane tap, lane i at [i*TAP_WIDTH +: TAP_WIDTH]
//   tap_load        per-lane one-cycle load strobe aligned with tap_value
//   busy            calibration in progress
//   done            one-cycle completion pulse
//   lane_fail       sticky per-lane failure, cleared on start
//   eye_width       per-lane best window length (only with HISPI_CALIB_EYE_EN)
// Optional feature macro: HISPI_CALIB_EYE_EN
// -----------------------------------------------------------------------------
module hispi_lane_calib_ctrl
    import hispi_calib_pkg::*;
#(
    parameter int unsigned NUMB_LANE     = DEF_NUMB_LANE,
    parameter int unsigned TAP_WIDTH     = DEF_TAP_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int unsigned MIN_WINDOW    = DEF_MIN_WINDOW
) (
    input  logic                           sysclk,
    input  logic                           sysrst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUMB_LANE-1:0]           pattern_ok,
    output logic [NUMB_LANE*TAP_WIDTH-1:0] tap_value,
    output logic [NUMB_LANE-1:0]           tap_load,
    output logic                           busy,
    output logic                           done,
    output logic [NUMB_LANE-1:0]           lane_fail
`ifdef HISPI_CALIB_EYE_EN
    ,
    output logic [NUMB_LANE*(TAP_WIDTH+1)-1:0] eye_width
`endif
);

    localparam int unsigned LANE_W  = (NUMB_LANE > 1) ? $clog2(NUMB_LANE) : 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES
                                                                      : SAMPLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;
    localparam logic [LANE_W-1:0]    LANE_LAST   = LANE_W'(NUMB_LANE - 1);
    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_WIDTH:0]   MIN_LEN     = (TAP_WIDTH+1)'(MIN_WINDOW);

    calib_state_t         state;
    logic [LANE_W-1:0]    lane;
    logic [TAP_WIDTH-1:0] tap;
    logic [CNT_W-1:0]     cnt;
    logic                 pat_acc;

    logic                 win_clear;
    logic                 win_valid;
    logic                 win_last;
    logic [TAP_WIDTH-1:0] best_start;
    logic [TAP_WIDTH:0]   best_len;

    logic                 lane_ok;
    logic                 window_good;
    int unsigned          center;
    logic [TAP_WIDTH-1:0] final_tap;
    logic                 start_ok;

    always_comb begin
        lane_ok     = pattern_ok[lane];
        start_ok    = (state == StIdle) && start && !abort;
        win_clear   = start_ok || ((state == StNext) && !abort);
        win_valid   = (state == StEval) && !abort;
        win_last    = (tap == TAP_MAX);
        window_good = (best_len >= MIN_LEN);
        center      = calc_center(32'(best_start), 32'(best_len));
        final_tap   = window_good ? TAP_WIDTH'(center) : '0;
    end

    hispi_calib_window #(
        .TAP_WIDTH (TAP_WIDTH)
    ) u_window (
        .clk        (sysclk),
        .rst        (sysrst),
        .clear      (win_clear),
        .valid      (win_valid),
        .pass       (pat_acc),
        .last       (win_last),
        .tap        (tap),
        .best_start (best_start),
        .best_len   (best_len)
    );

    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state     <= StIdle;
            lane      <= '0;
            tap       <= '0;
            cnt       <= '0;
            pat_acc   <= 1'b0;
            tap_value <= '0;
            tap_load  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lane_fail <= '0;
`ifdef HISPI_CALIB_EYE_EN
            eye_width <= '0;
`endif
        end else begin
            tap_load <= '0;
            done     <= 1'b0;
            if ((state != StIdle) && abort) begin
                // Committed taps and lane_fail are left as they are.
                state <= StIdle;
                busy  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start_ok) begin
                            state     <= StLoad;
                            lane      <= '0;
                            tap       <= '0;
                            cnt       <= '0;
                            lane_fail <= '0;
                            busy      <= 1'b1;
`ifdef HISPI_CALIB_EYE_EN
                            eye_width <= '0;
`endif
                        end
                    end
                    StLoad: begin
                        tap_value[lane*TAP_WIDTH +: TAP_WIDTH] <= tap;
                        tap_load[lane] <= 1'b1;
                        cnt            <= '0;
                        state          <= StSettle;
                    end
                    StSettle: begin
                        if (cnt == SETTLE_LAST) begin
                            cnt     <= '0;
                            pat_acc <= 1'b1;
                            state   <= StSample;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    StSample: begin
                        // Fixed-length sample; one low cycle fails the tap.
                        pat_acc <= pat_acc & lane_ok;
                        if (cnt == SAMPLE_LAST) begin
                            cnt   <= '0;
                            state <= StEval;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    StEval: begin
                        if (tap == TAP_MAX) begin
                            state <= StCenter;
                        end else begin
                            tap   <= tap + TAP_WIDTH'(1);
                            state <= StLoad;
                        end
                    end
                    StCenter: begin
                        tap_value[lane*TAP_WIDTH +: TAP_WIDTH] <= final_tap;
                        tap_load[lane] <= 1'b1;
                        if (!window_good) begin
                            lane_fail[lane] <= 1'b1;
                        end
`ifdef HISPI_CALIB_EYE_EN
                        eye_width[lane*(TAP_WIDTH+1) +: (TAP_WIDTH+1)] <= best_len;
`endif
                        state <= StNext;
                    end
                    StNext: begin
                        tap <= '0;
                        if (lane == LANE_LAST) begin
                            state <= StDone;
                        end else begin
                            lane  <= lane + LANE_W'(1);
                            state <= StLoad;
                        end
                    end
                    StDone: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hispi_lane_calib_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hispi_lane_calib_ctrl
// Directed bench: two lanes, 5-bit taps, short settle/sample counts. A small
// delay-line stand-in drives pattern_ok from a per-lane pass mask indexed by
// the tap most recently loaded into that lane.
// -----------------------------------------------------------------------------
module tb_hispi_lane_calib_ctrl;

    localparam int NL   = 2;
    localparam int TW   = 5;
    localparam int SC   = 3;
    localparam int MC   = 4;
    localparam int MINW = 4;
    // Per lane: 32 taps * (LOAD+SETTLE+SAMPLE+EVAL) + CENTER + NEXT; plus DONE,
    // plus one negedge offset between the start edge and the first count.
    localparam int LAT  = NL * (32 * (1 + SC + MC + 1) + 2) + 2;

    logic              sysclk = 1'b0;
    logic              sysrst = 1'b1;
    logic              start  = 1'b0;
    logic              abort  = 1'b0;
    logic [NL-1:0]     pattern_ok;
    logic [NL*TW-1:0]  tap_value;
    logic [NL-1:0]     tap_load;
    logic              busy;
    logic              done;
    logic [NL-1:0]     lane_fail;
`ifdef HISPI_CALIB_EYE_EN
    logic [NL*(TW+1)-1:0] eye_width;
`endif

    always #5 sysclk = ~sysclk;

    hispi_lane_calib_ctrl #(
        .NUMB_LANE     (NL),
        .TAP_WIDTH     (TW),
        .SETTLE_CYCLES (SC),
        .SAMPLE_CYCLES (MC),
        .MIN_WINDOW    (MINW)
    ) dut (
        .sysclk     (sysclk),
        .sysrst     (sysrst),
        .start      (start),
        .abort      (abort),
        .pattern_ok (pattern_ok),
        .tap_value  (tap_value),
        .tap_load   (tap_load),
        .busy       (busy),
        .done       (done),
        .lane_fail  (lane_fail)
`ifdef HISPI_CALIB_EYE_EN
        ,
        .eye_width  (eye_width)
`endif
    );

    logic [31:0] mask0 = '0;
    logic [31:0] mask1 = '0;
    logic [TW-1:0] cur_tap0 = '0;
    logic [TW-1:0] cur_tap1 = '0;
    int  since = 0;
    bit  glitch_en = 1'b0;
    int  done_cnt = 0;
    int  tests = 0;
    int  fails = 0;

    // Delay-line stand-in: remember what each lane was last loaded with.
    always @(posedge sysclk) begin
        if (tap_load[0]) cur_tap0 <= tap_value[0 +: TW];
        if (tap_load[1]) cur_tap1 <= tap_value[TW +: TW];
        since <= tap_load[0] ? 1 : since + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // since == SC+1 lands in the second SAMPLE cycle of a lane-0 tap.
    always_comb begin
        pattern_ok[0] = mask0[cur_tap0] && !(glitch_en && cur_tap0 == 5'd12 && since == SC + 1);
        pattern_ok[1] = mask1[cur_tap1];
    end

    function automatic logic [31:0] range_mask(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then wait for done. restart_at re-pulses start mid-run.
    task automatic run_cal(input int restart_at, output int cycles);
        int n;
        bit seen;
        @(negedge sysclk);
        start = 1'b1;
        @(posedge sysclk);
        #1 start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 4000 && !seen) begin
            @(negedge sysclk);
            n++;
            start = (n == restart_at);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        cycles = seen ? n : 0;
    endtask

    task automatic finish_run(input string tag, input int exp0, input int exp1,
                              input int exp_fail);
        int cyc;
        int d0;
        d0 = done_cnt;
        run_cal(0, cyc);
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        @(negedge sysclk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_done_low"}, {31'd0, done}, 0);
        check({tag, "_tap0"}, tap_value[0 +: TW], exp0);
        check({tag, "_tap1"}, tap_value[TW +: TW], exp1);
        check({tag, "_lane_fail"}, lane_fail, exp_fail);
    endtask

    initial begin
        int cyc;
        int d0;
        int n;

        // Reset values
        repeat (2) @(negedge sysclk);
        check("rst_tap_value", tap_value, 0);
        check("rst_tap_load", tap_load, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_lane_fail", lane_fail, 0);
        sysrst = 1'b0;
        @(negedge sysclk);

        // Basic: lane0 10..19 -> 15, lane1 3..6 -> 5; a start mid-run is ignored
        mask0 = range_mask(10, 19);
        mask1 = range_mask(3, 6);
        d0 = done_cnt;
        run_cal(100, cyc);
        check("t1_latency", cyc, LAT);
        @(negedge sysclk);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_tap0", tap_value[0 +: TW], 15);
        check("t1_tap1", tap_value[TW +: TW], 5);
        check("t1_lane_fail", lane_fail, 0);
`ifdef HISPI_CALIB_EYE_EN
        check("t1_eye0", eye_width[0 +: TW+1], 10);
        check("t1_eye1", eye_width[TW+1 +: TW+1], 4);
`endif

        // Equal windows 4..7 and 20..23: earlier kept -> 4+2=6; lane1 8..17 -> 13
        mask0 = range_mask(4, 7) | range_mask(20, 23);
        mask1 = range_mask(8, 17);
        finish_run("t2", 6, 13, 0);

        // Lane1 only 0..2 (len 3 < 4): tap 0 and lane_fail[1]
        mask0 = range_mask(10, 19);
        mask1 = range_mask(0, 2);
        finish_run("t3", 15, 0, 2);

        // Abort during lane1 SETTLE; start clears lane_fail left over from t3
        mask0 = range_mask(10, 19);
        mask1 = range_mask(3, 6);
        d0 = done_cnt;
        @(negedge sysclk);
        start = 1'b1;
        @(posedge sysclk);
        #1 start = 1'b0;
        @(negedge sysclk);
        check("t6_busy_after_start", {31'd0, busy}, 1);
        check("t6_lane_fail_cleared", lane_fail, 0);
        n = 0;
        while (n < 2000 && !tap_load[1]) begin
            @(negedge sysclk);
            n++;
        end
        check("t6_lane1_load_seen", {31'd0, tap_load[1]}, 1);
        abort = 1'b1;
        @(negedge sysclk);
        abort = 1'b0;
        check("t6_busy_after_abort", {31'd0, busy}, 0);
        check("t6_tap0_kept", tap_value[0 +: TW], 15);
        check("t6_tap1_last_loaded", tap_value[TW +: TW], 0);
        repeat (40) @(negedge sysclk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_still_idle", {31'd0, busy}, 0);
        finish_run("t6_rerun", 15, 5, 0);

        // All 32 taps pass on lane0: length 32, centre 16
        mask0 = 32'hFFFF_FFFF;
        mask1 = range_mask(3, 6);
        finish_run("t4", 16, 5, 0);
`ifdef HISPI_CALIB_EYE_EN
        check("t4_eye0", eye_width[0 +: TW+1], 32);
`endif

        // One-cycle drop on tap 12: windows 10..11 and 13..19 -> 13+3=16
        mask0 = range_mask(10, 19);
        glitch_en = 1'b1;
        finish_run("t5", 16, 5, 0);
        glitch_en = 1'b0;

        // Simultaneous start and abort in idle: stays idle
        @(negedge sysclk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", {31'd0, busy}, 0);
        @(negedge sysclk);
        check("sa_busy_later", {31'd0, busy}, 0);

        // Reset mid-operation
        @(negedge sysclk);
        start = 1'b1;
        @(posedge sysclk);
        #1 start = 1'b0;
        repeat (50) @(negedge sysclk);
        check("mr_busy_before", {31'd0, busy}, 1);
        sysrst = 1'b1;
        #1;
        check("mr_tap_value", tap_value, 0);
        check("mr_tap_load", tap_load, 0);
        check("mr_busy", {31'd0, busy}, 0);
        check("mr_lane_fail", lane_fail, 0);
        @(negedge sysclk);
        sysrst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
